// File: rtl/fpu_op_sequencer_pkg.sv
// fp_seq_pkg: shared definitions for the FPU operation sequencer.
//   - op codes forwarded to the FPU
//   - response status codes
//   - quiet-NaN result returned on timeout
//   - sequencer state enumeration
package fp_seq_pkg;

  localparam logic [1:0]  OP_ADD     = 2'b00;
  localparam logic [1:0]  OP_MULT    = 2'b10;

  localparam logic [1:0]  ST_OK      = 2'b00;
  localparam logic [1:0]  ST_ILLEGAL = 2'b01;
  localparam logic [1:0]  ST_TIMEOUT = 2'b10;

  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_RESP
  } seq_state_t;

  // Every op code with bit 0 set is rejected without touching the FPU.
  function automatic logic op_is_illegal(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_watchdog.sv
// fpu_watchdog: CNT_W-bit up-counter with synchronous clear, count enable
// and a terminal-compare output against a run-time limit.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear to zero (priority over en)
//   en         : count enable; the counter holds once it reaches limit
//   limit      : terminal value
//   term       : high while the count equals limit
module fpu_watchdog
  import fp_seq_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] count;

  assign term = (count == limit);

  // Saturates at limit instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: initiator side of the FPU start/op/done handshake.
// Accepts (A, B, op) requests over a valid/ready port, clears the FPU,
// starts it, waits for done (with a watchdog timeout) and returns the
// result and status over a valid/ready response port.
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake (req_ready = state is IDLE)
//   req_a, req_b, req_op : single-precision operands and op code
//   rsp_valid/rsp_ready  : response handshake
//   rsp_result           : result word (0 for illegal op, qNaN on timeout)
//   rsp_status           : 00 ok, 01 illegal op, 10 timeout
//   busy                 : high in every state except IDLE
//   fpu_clr, fpu_start   : FPU re-init and start (start held as a level)
//   fpu_op, fpu_a, fpu_b : registered op code and operands to the FPU
//   fpu_done, fpu_result : FPU completion level and packed result
module fpu_op_sequencer
  import fp_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7,
  parameter int CLR_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic        fpu_clr,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result
);

  seq_state_t       state, state_d;
  logic [31:0]      fpu_a_d, fpu_b_d, rsp_result_d;
  logic [1:0]       fpu_op_d, rsp_status_d;
  logic             accept;
  logic             wd_clr, wd_en, wd_term;
  logic [CNT_W-1:0] wd_limit;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // One counter serves both the CLEAR hold and the WAIT timeout; it is
  // held at zero in IDLE and START so each phase starts counting from 0.
  fpu_watchdog #(
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .limit (wd_limit),
    .term  (wd_term)
  );

  always_comb begin
    state_d      = state;
    fpu_a_d      = fpu_a;
    fpu_b_d      = fpu_b;
    fpu_op_d     = fpu_op;
    rsp_result_d = rsp_result;
    rsp_status_d = rsp_status;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    wd_limit     = CNT_W'(TIMEOUT_CYCLES - 1);

    unique case (state)
      S_IDLE: begin
        wd_clr = 1'b1;
        if (accept) begin
          fpu_a_d      = req_a;
          fpu_b_d      = req_b;
          fpu_op_d     = req_op;
          rsp_result_d = '0;
          if (op_is_illegal(req_op)) begin
            rsp_status_d = ST_ILLEGAL;
            state_d      = S_RESP;
          end else begin
            rsp_status_d = ST_OK;
            state_d      = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        wd_en    = 1'b1;
        wd_limit = CNT_W'(CLR_CYCLES - 1);
        if (wd_term) begin
          state_d = S_START;
        end
      end

      S_START: begin
        wd_clr  = 1'b1;
        state_d = S_WAIT;
      end

      // Done has priority over a timeout in the same cycle.
      S_WAIT: begin
        wd_en = 1'b1;
        if (fpu_done) begin
          rsp_result_d = fpu_result;
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
        end else if (wd_term) begin
          rsp_result_d = QNAN;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs are registered copies decoded from the next state, so
  // they line up with the state register and drop asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      fpu_clr    <= 1'b0;
      fpu_start  <= 1'b0;
    end else begin
      state      <= state_d;
      fpu_a      <= fpu_a_d;
      fpu_b      <= fpu_b_d;
      fpu_op     <= fpu_op_d;
      rsp_result <= rsp_result_d;
      rsp_status <= rsp_status_d;
      rsp_valid  <= (state_d == S_RESP);
      busy       <= (state_d != S_IDLE);
      fpu_clr    <= (state_d == S_CLEAR);
      fpu_start  <= (state_d == S_START) || (state_d == S_WAIT);
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with a behavioural FPU stub.
module tb_fpu_op_sequencer;
  import fp_seq_pkg::*;

  localparam int TIMEOUT_CYCLES = 64;
  localparam int CLR_CYCLES     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  req_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        fpu_clr;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_result;

  always #5 clk = ~clk;

  fpu_op_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (7),
    .CLR_CYCLES     (CLR_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .busy       (busy),
    .fpu_clr    (fpu_clr),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result)
  );

  // FPU stub: counts cycles with start high, raises done after model_delay
  // such cycles (0 = never), holds done until fpu_clr.
  int          model_delay = 0;
  logic [31:0] model_result = '0;
  logic        stale_force = 1'b0;
  logic        m_done = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (fpu_clr) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (fpu_start && !m_done) begin
      m_cnt <= m_cnt + 1;
      if (model_delay != 0 && m_cnt + 1 >= model_delay) m_done <= 1'b1;
    end
  end

  assign fpu_done   = m_done | stale_force;
  assign fpu_result = fpu_done ? model_result : 32'hDEAD_BEEF;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  st;
    int          clr_n;
    int          start_n;
    int          lat;
    bit          gap;
    bit          tmo;
    bit          unstable;
    bit          rr_bad;
    logic [1:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        valid_after;
    logic        ready_after;
  } obs_t;

  // Drives one request starting at a negedge in IDLE, collects observations,
  // holds rsp_ready low for 'stall' cycles, then completes the handshake.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input int dly, input logic [31:0] mres,
                         input logic [31:0] exp_res, input logic [1:0] exp_st,
                         input int stall, input bit stale, output obs_t o);
    o = '{default: 0};
    model_delay  = dly;
    model_result = mres;
    stale_force  = stale;
    exp_q.push_back({exp_st, exp_res});
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    o.op1 = fpu_op; o.a1 = fpu_a; o.b1 = fpu_b; o.lat = 1;
    while (rsp_valid !== 1'b1 && o.lat < 200) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) o.rr_bad = 1'b1;
      if (fpu_clr === 1'b1) o.clr_n++;
      if (fpu_start === 1'b1) begin
        o.start_n++;
        stale_force = 1'b0;
      end else if (o.start_n > 0) begin
        o.gap = 1'b1;
      end
      @(negedge clk);
      o.lat++;
    end
    o.tmo = (rsp_valid !== 1'b1);
    o.res = rsp_result;
    o.st  = rsp_status;
    if (fpu_start !== 1'b0 || fpu_clr !== 1'b0 || req_ready !== 1'b0) o.unstable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== o.res || rsp_status !== o.st ||
          req_ready !== 1'b0 || fpu_start !== 1'b0 || fpu_clr !== 1'b0) o.unstable = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    o.valid_after = rsp_valid;
    o.ready_after = req_ready;
  endtask

  task automatic test_reset();
    logic [108:0] got, want;
    reset = 1'b1;
    #2;
    got  = {rsp_valid, rsp_result, rsp_status, busy, fpu_clr, fpu_start, fpu_op, fpu_a, fpu_b, req_ready};
    want = {1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", got, want);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    obs_t o;
    run_txn(32'h3F80_0000, 32'h4000_0000, OP_ADD, 10, 32'h4040_0000, 32'h4040_0000, ST_OK, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp) begin
      miscompares++; $display("FAIL add_result: got %h want %h", {o.st, o.res}, exp);
    end
    vectors++;
    if (o.clr_n != CLR_CYCLES) begin
      miscompares++; $display("FAIL add_clr_cycles: got %0d want %0d", o.clr_n, CLR_CYCLES);
    end
    vectors++;
    if (o.start_n != 11 || o.gap) begin
      miscompares++; $display("FAIL add_start_held: got %0d gap %0d want 11 gap 0", o.start_n, o.gap);
    end
    vectors++;
    if (o.lat != CLR_CYCLES + 2 + 10) begin
      miscompares++; $display("FAIL add_latency: got %0d want %0d", o.lat, CLR_CYCLES + 12);
    end
    vectors++;
    if ({o.op1, o.a1, o.b1} !== {OP_ADD, 32'h3F80_0000, 32'h4000_0000}) begin
      miscompares++; $display("FAIL add_operands: got %h %h %h", o.op1, o.a1, o.b1);
    end
    vectors++;
    if (o.rr_bad || o.unstable || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
      miscompares++;
      $display("FAIL add_handshake: got rr_bad %0d unstable %0d valid %b ready %b want 0 0 0 1",
               o.rr_bad, o.unstable, o.valid_after, o.ready_after);
    end
  endtask

  task automatic test_mult();
    obs_t o;
    run_txn(32'h4000_0000, 32'h4040_0000, OP_MULT, 4, 32'h40C0_0000, 32'h40C0_0000, ST_OK, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp) begin
      miscompares++; $display("FAIL mult_result: got %h want %h", {o.st, o.res}, exp);
    end
    vectors++;
    if (o.op1 !== 2'b10 || o.lat != CLR_CYCLES + 2 + 4) begin
      miscompares++; $display("FAIL mult_op_latency: got op %b lat %0d want op 10 lat %0d", o.op1, o.lat, CLR_CYCLES + 6);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    run_txn(32'h1111_1111, 32'h2222_2222, 2'b01, 3, 32'h5555_5555, 32'h0, ST_ILLEGAL, 2, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp) begin
      miscompares++; $display("FAIL illegal01_result: got %h want %h", {o.st, o.res}, exp);
    end
    vectors++;
    if (o.lat != 1 || o.clr_n != 0 || o.start_n != 0 || o.unstable) begin
      miscompares++;
      $display("FAIL illegal01_fpu_untouched: got lat %0d clr %0d start %0d unstable %0d want 1 0 0 0",
               o.lat, o.clr_n, o.start_n, o.unstable);
    end
    run_txn(32'h0, 32'h0, 2'b11, 3, 32'h5555_5555, 32'h0, ST_ILLEGAL, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp || o.op1 !== 2'b11 || o.lat != 1) begin
      miscompares++; $display("FAIL illegal11: got %h op %b lat %0d want %h op 11 lat 1", {o.st, o.res}, o.op1, o.lat, exp);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 0, 32'h4000_0000, QNAN, ST_TIMEOUT, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp) begin
      miscompares++; $display("FAIL timeout_result: got %h want %h", {o.st, o.res}, exp);
    end
    vectors++;
    if (o.start_n != TIMEOUT_CYCLES + 1 || o.lat != CLR_CYCLES + 2 + TIMEOUT_CYCLES) begin
      miscompares++;
      $display("FAIL timeout_wait_cycles: got start %0d lat %0d want %0d %0d",
               o.start_n, o.lat, TIMEOUT_CYCLES + 1, CLR_CYCLES + 2 + TIMEOUT_CYCLES);
    end
    // Done arriving on the last WAIT cycle wins over the timeout.
    run_txn(32'h3F80_0000, 32'h3F80_0000, OP_ADD, TIMEOUT_CYCLES, 32'h4000_0000, 32'h4000_0000, ST_OK, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp || o.lat != CLR_CYCLES + 2 + TIMEOUT_CYCLES) begin
      miscompares++; $display("FAIL done_on_last_wait: got %h lat %0d want %h", {o.st, o.res}, o.lat, exp);
    end
    // One cycle too late: timeout.
    run_txn(32'h3F80_0000, 32'h3F80_0000, OP_ADD, TIMEOUT_CYCLES + 1, 32'h4000_0000, QNAN, ST_TIMEOUT, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp) begin
      miscompares++; $display("FAIL done_after_timeout: got %h want %h", {o.st, o.res}, exp);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    bit idle_bad = 1'b0;
    run_txn(32'h4000_0000, 32'h4000_0000, OP_MULT, 3, 32'h4080_0000, 32'h4080_0000, ST_OK, 5, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp || o.unstable || o.valid_after !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_stable: got %h unstable %0d valid_after %b want %h 0 0",
               {o.st, o.res}, o.unstable, o.valid_after, exp);
    end
    // Stale done present in IDLE and CLEAR must not be taken.
    stale_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) idle_bad = 1'b1;
    end
    vectors++;
    if (idle_bad) begin
      miscompares++; $display("FAIL stale_done_idle: got reaction to done in IDLE want none");
    end
    run_txn(32'h3F80_0000, 32'h4000_0000, OP_ADD, 5, 32'h4040_0000, 32'h4040_0000, ST_OK, 0, 1'b1, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp || o.lat != CLR_CYCLES + 2 + 5) begin
      miscompares++; $display("FAIL stale_done_clear: got %h lat %0d want %h lat %0d", {o.st, o.res}, o.lat, exp, CLR_CYCLES + 7);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_txn(32'h4000_0000, 32'h4040_0000, OP_MULT, 2, 32'h40C0_0000, 32'h40C0_0000, ST_OK, 0, 1'b0, o1);
    run_txn(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 1, 32'h4000_0000, 32'h4000_0000, ST_OK, 0, 1'b0, o2);
    exp = exp_q.pop_front();
    vectors++;
    if (o1.tmo || {o1.st, o1.res} !== exp || o1.ready_after !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first: got %h ready %b want %h ready 1", {o1.st, o1.res}, o1.ready_after, exp);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (o2.tmo || {o2.st, o2.res} !== exp || o2.lat != CLR_CYCLES + 3 || o2.op1 !== OP_ADD) begin
      miscompares++; $display("FAIL b2b_second: got %h lat %0d want %h lat %0d", {o2.st, o2.res}, o2.lat, exp, CLR_CYCLES + 3);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [108:0] got, want;
    model_delay = 0;
    req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_op = OP_ADD; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (CLR_CYCLES + 4) @(negedge clk);
    vectors++;
    if (fpu_start !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_in_wait: got start %b busy %b want 1 1", fpu_start, busy);
    end
    #2 reset = 1'b1;
    #1;
    got  = {rsp_valid, rsp_result, rsp_status, busy, fpu_clr, fpu_start, fpu_op, fpu_a, fpu_b, req_ready};
    want = {1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_mid_async: got %h want %h", got, want);
    end
    @(negedge clk);
    reset = 1'b0;
    run_txn(32'h3F80_0000, 32'h4000_0000, OP_ADD, 10, 32'h4040_0000, 32'h4040_0000, ST_OK, 0, 1'b0, o);
    exp = exp_q.pop_front();
    vectors++;
    if (o.tmo || {o.st, o.res} !== exp || o.lat != CLR_CYCLES + 12) begin
      miscompares++; $display("FAIL reset_mid_recover: got %h lat %0d want %h", {o.st, o.res}, o.lat, exp);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish want finish before 200000");
    $fatal(1, "time limit");
  end

endmodule
